ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the write path back to the keyboard, opposite direction to the keyboard scan-code receiver/decoder.
- Sends one command byte per request (e.g. 0xED set-LEDs, 0xFF reset) using the PS/2 request-to-send sequence: inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK.
- Runs on the system clock and drives the bidirectional PS/2 clock and data lines through open-drain enables; the tri-state pads are outside this block.

Parameters:
- INHIBIT_CYCLES, 5000, system-clock cycles the PS/2 clock is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, maximum system-clock cycles from start-bit release to the ACK-phase completion (20 ms at 50 MHz).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- ARST_L  in  1  asynchronous, active-low reset.
- TX_DATA  in  8  command byte; sampled only when TX_START is accepted.
- TX_START  in  1  one-cycle request; accepted only in IDLE.
- BUSY  out  1  high from acceptance through DONE/ACK_ERR/TIMEOUT cycle inclusive.
- DONE  out  1  one-cycle pulse when the byte has been sent and ACKed.
- ACK_ERR  out  1  one-cycle pulse when the device did not ACK (data high at 11th falling edge).
- TIMEOUT  out  1  one-cycle pulse when TIMEOUT_CYCLES expires.
- PS2CLK_IN  in  1  raw PS/2 clock line level (asynchronous).
- PS2DATA_IN  in  1  raw PS/2 data line level (asynchronous).
- PS2CLK_OE  out  1  1 = pull PS/2 clock low; 0 = release.
- PS2DATA_OE  out  1  1 = pull PS/2 data low; 0 = release.

Behaviour:
- Reset (ARST_L=0, async): state IDLE; BUSY, DONE, ACK_ERR, TIMEOUT, PS2CLK_OE, PS2DATA_OE all 0; line synchronisers preset to 1; counters 0. Reset mid-transfer releases both lines immediately.
- Synchronise both inputs through 2 flops. A falling edge is sync'd clock previous=1, current=0, detected one cycle after the second stage.
- IDLE: lines released. TX_START=1 -> latch TX_DATA, compute parity = ~^TX_DATA, BUSY=1, go INHIBIT next cycle.
- INHIBIT: PS2CLK_OE=1, PS2DATA_OE=0 for exactly INHIBIT_CYCLES cycles. Edges ignored.
- RTS: one cycle with PS2CLK_OE=1, PS2DATA_OE=1.
- SEND: PS2CLK_OE=0, PS2DATA_OE=1 (start bit). Clear timeout counter and bit index. On each detected falling edge, at index n: n=0..7 drive data bit n (PS2DATA_OE = ~bit); n=8 drive parity; n=9 release data (stop). Then increment index. Line value changes only on falling-edge cycles.
- ACK: on the next (11th) falling edge, sample sync'd data. 0 means ACK, go WAIT_IDLE. 1 means NACK, pulse ACK_ERR, go IDLE.
- WAIT_IDLE: wait until sync'd clock=1 and data=1, pulse DONE, go IDLE.
- Timeout counter runs in SEND, ACK, and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1 without completion: release both lines, pulse TIMEOUT, go IDLE. Timeout has priority over an edge in the same cycle.
- BUSY drops the cycle after the DONE, ACK_ERR, or TIMEOUT pulse. A new TX_START is accepted on that cycle.
- TX_START while BUSY is ignored; no queueing. TX_DATA changes after acceptance have no effect.
- DONE, ACK_ERR, and TIMEOUT are mutually exclusive.
- Falling edges seen during IDLE (keyboard traffic) have no effect.

Test Plan:
- INHIBIT_CYCLES=20, TX_DATA=0xED, TX_START pulse, bench device model clocks at 10 kHz-equivalent and ACKs -> PS2CLK_OE high 20 cycles, then 1 RTS cycle. Data bits seen by device: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. DONE pulses once; BUSY then drops.
- TX_DATA=0x00 -> parity bit 1; TX_DATA=0x01 -> parity bit 0. Verify on the 9th falling edge.
- Device keeps data high at the 11th edge -> ACK_ERR one-cycle pulse; DONE and TIMEOUT stay 0; lines released.
- Device stops clocking after 4 bits, TIMEOUT_CYCLES=500 -> TIMEOUT pulses exactly 500 cycles after SEND entry. PS2DATA_OE=0 and PS2CLK_OE=0 the following cycle.
- ARST_L low during SEND bit 5 -> both OE outputs 0 asynchronously. After release the block is in IDLE and accepts a new TX_START=0xFF, which completes with DONE.
- TX_START pulsed again mid-transfer, and keyboard edges injected while IDLE -> no state change, no extra output pulses.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Bundles the request/status handshake and the PS/2 line signals of the
// PS/2 host transmitter.
//   TX_DATA    : command byte, sampled when a request is accepted
//   TX_START   : one-cycle send request
//   BUSY       : transfer in progress, including the final status-pulse cycle
//   DONE       : byte sent and acknowledged by the device (one-cycle pulse)
//   ACK_ERR    : device did not acknowledge (one-cycle pulse)
//   TIMEOUT    : device stopped clocking (one-cycle pulse)
//   PS2CLK_IN  : raw PS/2 clock line level
//   PS2DATA_IN : raw PS/2 data line level
//   PS2CLK_OE  : 1 pulls the PS/2 clock line low
//   PS2DATA_OE : 1 pulls the PS/2 data line low
// The master modport is the requester/line side; the slave modport is the
// transmitter itself.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       BUSY;
  logic       DONE;
  logic       ACK_ERR;
  logic       TIMEOUT;
  logic       PS2CLK_IN;
  logic       PS2DATA_IN;
  logic       PS2CLK_OE;
  logic       PS2DATA_OE;

  modport master (
    output TX_DATA, TX_START, PS2CLK_IN, PS2DATA_IN,
    input  BUSY, DONE, ACK_ERR, TIMEOUT, PS2CLK_OE, PS2DATA_OE
  );

  modport slave (
    input  TX_DATA, TX_START, PS2CLK_IN, PS2DATA_IN,
    output BUSY, DONE, ACK_ERR, TIMEOUT, PS2CLK_OE, PS2DATA_OE
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte per request using
// the request-to-send sequence: clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop bit and device ACK. The PS/2 lines are driven via
// open-drain enables; the pads live outside this block.
// Ports:
//   CLK    : system clock, all state changes on the rising edge
//   ARST_L : asynchronous active-low reset
//   bus    : request/status handshake and PS/2 line signals (slave side)
// Parameters:
//   INHIBIT_CYCLES : cycles the PS/2 clock is held low before the start bit
//   TIMEOUT_CYCLES : cycle budget from start-bit release to ACK completion
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic          CLK,
  input logic          ARST_L,
  ps2_host_tx_if.slave bus
);

  // One counter serves both the inhibit interval and the timeout budget.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [3:0]      r_idx, w_idx;
  logic [7:0]      r_data, w_data;
  logic            r_parity, w_parity;
  logic            r_clkOe, w_clkOe;
  logic            r_dataOe, w_dataOe;
  logic            r_done, w_done;
  logic            r_ackErr, w_ackErr;
  logic            r_timeout, w_timeout;
  logic [1:0]      r_clkSync, r_datSync;
  logic            r_clkPrev;
  logic            w_fall;
  logic            w_busy;
  logic            w_timedOut;

  // A status pulse is registered together with the return to IDLE, so BUSY
  // stays high through the pulse cycle and drops on the cycle after it.
  assign w_busy     = (r_state != S_IDLE) | r_done | r_ackErr | r_timeout;
  assign w_fall     = r_clkPrev & ~r_clkSync[1];
  assign w_timedOut = ((r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE))
                      && (r_cnt == TO_LAST);

  assign bus.BUSY       = w_busy;
  assign bus.DONE       = r_done;
  assign bus.ACK_ERR    = r_ackErr;
  assign bus.TIMEOUT    = r_timeout;
  assign bus.PS2CLK_OE  = r_clkOe;
  assign bus.PS2DATA_OE = r_dataOe;

  // State and datapath registers, plus two-flop line synchronisers preset to
  // the idle (released, high) line level.
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_clkOe   <= 1'b0;
      r_dataOe  <= 1'b0;
      r_done    <= 1'b0;
      r_ackErr  <= 1'b0;
      r_timeout <= 1'b0;
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
      r_clkPrev <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_data    <= w_data;
      r_parity  <= w_parity;
      r_clkOe   <= w_clkOe;
      r_dataOe  <= w_dataOe;
      r_done    <= w_done;
      r_ackErr  <= w_ackErr;
      r_timeout <= w_timeout;
      r_clkSync <= {r_clkSync[0], bus.PS2CLK_IN};
      r_datSync <= {r_datSync[0], bus.PS2DATA_IN};
      r_clkPrev <= r_clkSync[1];
    end
  end

  // Next-state and line-drive logic. Line enables are registered so they
  // only change on the cycle after a decision, never glitching between
  // state encodings. The timeout check is applied last so it overrides a
  // falling edge seen in the same cycle.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_idx     = r_idx;
    w_data    = r_data;
    w_parity  = r_parity;
    w_clkOe   = r_clkOe;
    w_dataOe  = r_dataOe;
    w_done    = 1'b0;
    w_ackErr  = 1'b0;
    w_timeout = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clkOe  = 1'b0;
        w_dataOe = 1'b0;
        w_cnt    = '0;
        if (bus.TX_START && !w_busy) begin
          w_data   = bus.TX_DATA;
          w_parity = ~^bus.TX_DATA;
          w_clkOe  = 1'b1;
          w_state  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_dataOe = 1'b1;
          w_state  = S_RTS;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_RTS: begin
        w_clkOe = 1'b0;
        w_cnt   = '0;
        w_idx   = '0;
        w_state = S_SEND;
      end
      S_SEND: begin
        w_cnt = r_cnt + 1'b1;
        if (w_fall) begin
          w_idx = r_idx + 1'b1;
          if (r_idx < 4'd8) begin
            w_dataOe = ~r_data[r_idx[2:0]];
          end else if (r_idx == 4'd8) begin
            w_dataOe = ~r_parity;
          end else begin
            w_dataOe = 1'b0;
            w_state  = S_ACK;
          end
        end
      end
      S_ACK: begin
        w_cnt = r_cnt + 1'b1;
        if (w_fall) begin
          if (!r_datSync[1]) begin
            w_state = S_WAIT_IDLE;
          end else begin
            w_ackErr = 1'b1;
            w_state  = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_cnt = r_cnt + 1'b1;
        if (r_clkSync[1] && r_datSync[1]) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_clkOe  = 1'b0;
        w_dataOe = 1'b0;
        w_state  = S_IDLE;
      end
    endcase

    if (w_timedOut) begin
      w_clkOe   = 1'b0;
      w_dataOe  = 1'b0;
      w_done    = 1'b0;
      w_ackErr  = 1'b0;
      w_timeout = 1'b1;
      w_state   = S_IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a small PS/2 device model that
// generates the device clock, samples the host's bits and returns ACK/NACK.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int HALF = 15;

  logic CLK = 1'b0;
  logic ARST_L = 1'b1;
  logic devClkLow = 1'b0;
  logic devDataLow = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   doneCnt = 0;
  int   errCnt = 0;
  int   toCnt = 0;

  ps2_host_tx_if bus();

  // Open-drain wired-AND of host and device on both PS/2 lines.
  assign bus.PS2CLK_IN  = ~(bus.PS2CLK_OE | devClkLow);
  assign bus.PS2DATA_IN = ~(bus.PS2DATA_OE | devDataLow);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .CLK(CLK),
    .ARST_L(ARST_L),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Count cycles on which each status pulse is high.
  always @(negedge CLK) begin
    if (bus.DONE === 1'b1) doneCnt <= doneCnt + 1;
    if (bus.ACK_ERR === 1'b1) errCnt <= errCnt + 1;
    if (bus.TIMEOUT === 1'b1) toCnt <= toCnt + 1;
  end

  // Issue a one-cycle request; returns on the first cycle after acceptance.
  task automatic startTx(input logic [7:0] d);
    bus.TX_DATA  = d;
    bus.TX_START = 1'b1;
    @(negedge CLK);
    bus.TX_START = 1'b0;
  endtask

  // Count inhibit and RTS cycles until the start bit is presented.
  task automatic observeInhibit(output int inhCnt, output int rtsCnt, output int sendCyc, output bit ok);
    inhCnt = 0;
    rtsCnt = 0;
    sendCyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.PS2CLK_OE === 1'b1 && bus.PS2DATA_OE === 1'b0) inhCnt++;
      else if (bus.PS2CLK_OE === 1'b1 && bus.PS2DATA_OE === 1'b1) rtsCnt++;
      else if (bus.PS2CLK_OE === 1'b0 && bus.PS2DATA_OE === 1'b1) begin
        sendCyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // Device model: sample start bit, then generate nFalls clock pulses,
  // sampling the line in each low phase; the 11th pulse carries the ACK.
  task automatic deviceBits(input int nFalls, input bit ack, output logic [10:0] bits);
    bits = '0;
    repeat (HALF) @(negedge CLK);
    bits[0] = bus.PS2DATA_IN;
    for (int k = 1; k <= 10; k++) begin
      if (k <= nFalls) begin
        devClkLow = 1'b1;
        repeat (HALF) @(negedge CLK);
        bits[k] = bus.PS2DATA_IN;
        devClkLow = 1'b0;
        repeat (HALF) @(negedge CLK);
      end
    end
    if (nFalls >= 11) begin
      devDataLow = ack;
      repeat (2) @(negedge CLK);
      devClkLow = 1'b1;
      repeat (HALF) @(negedge CLK);
      devClkLow = 1'b0;
      repeat (2) @(negedge CLK);
      devDataLow = 1'b0;
    end
  endtask

  // Wait for DONE, then step to the cycle after it.
  task automatic waitDone(output bit ok, output logic busyAtDone);
    ok = 1'b0;
    busyAtDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE === 1'b1) begin
        ok = 1'b1;
        busyAtDone = bus.BUSY;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #2 ARST_L = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({bus.BUSY, bus.DONE, bus.ACK_ERR, bus.TIMEOUT, bus.PS2CLK_OE, bus.PS2DATA_OE} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 000000",
               {bus.BUSY, bus.DONE, bus.ACK_ERR, bus.TIMEOUT, bus.PS2CLK_OE, bus.PS2DATA_OE});
    end
    ARST_L = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_send_ed();
    int inhCnt, rtsCnt, sendCyc;
    bit ok, doneOk;
    logic busyAtDone;
    logic [10:0] bits;
    int d0, e0, t0;
    d0 = doneCnt; e0 = errCnt; t0 = toCnt;
    startTx(8'hED);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    total++;
    if (!ok || inhCnt != 20) begin
      bad++;
      $display("[TB] FAIL inhibit_len: got %0d (ok=%0d) want 20", inhCnt, ok);
    end
    total++;
    if (rtsCnt != 1) begin
      bad++;
      $display("[TB] FAIL rts_len: got %0d want 1", rtsCnt);
    end
    deviceBits(11, 1'b1, bits);
    total++;
    if (bits !== 11'h7DA) begin
      bad++;
      $display("[TB] FAIL frame_ed: got %h want 7da", bits);
    end
    waitDone(doneOk, busyAtDone);
    total++;
    if (!doneOk || busyAtDone !== 1'b1) begin
      bad++;
      $display("[TB] FAIL done_ed: seen=%0d busy=%b want seen=1 busy=1", doneOk, busyAtDone);
    end
    total++;
    if (bus.BUSY !== 1'b0 || (doneCnt - d0) != 1 || errCnt != e0 || toCnt != t0) begin
      bad++;
      $display("[TB] FAIL after_done_ed: busy=%b done=%0d err=%0d to=%0d want 0 1 0 0",
               bus.BUSY, doneCnt - d0, errCnt - e0, toCnt - t0);
    end
  endtask

  task automatic test_back_to_back();
    int inhCnt, rtsCnt, sendCyc;
    bit ok, doneOk;
    logic busyAtDone;
    logic [10:0] bits;
    startTx(8'h00);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    deviceBits(11, 1'b1, bits);
    total++;
    if (bits[9] !== 1'b1 || bits !== 11'h600) begin
      bad++;
      $display("[TB] FAIL parity_00: frame %h parity %b want 600 parity 1", bits, bits[9]);
    end
    waitDone(doneOk, busyAtDone);
    // Request on the very cycle BUSY drops.
    startTx(8'h01);
    total++;
    if (bus.BUSY !== 1'b1 || bus.PS2CLK_OE !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_accept: busy=%b clkoe=%b want 1 1", bus.BUSY, bus.PS2CLK_OE);
    end
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    deviceBits(11, 1'b1, bits);
    total++;
    if (bits[9] !== 1'b0 || bits !== 11'h402) begin
      bad++;
      $display("[TB] FAIL parity_01: frame %h parity %b want 402 parity 0", bits, bits[9]);
    end
    waitDone(doneOk, busyAtDone);
    total++;
    if (!doneOk) begin
      bad++;
      $display("[TB] FAIL done_01: seen=%0d want 1", doneOk);
    end
  endtask

  task automatic test_nack();
    int inhCnt, rtsCnt, sendCyc;
    bit ok;
    logic [10:0] bits;
    int d0, e0, t0;
    d0 = doneCnt; e0 = errCnt; t0 = toCnt;
    startTx(8'hF4);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    deviceBits(11, 1'b0, bits);
    repeat (5) @(negedge CLK);
    total++;
    if ((errCnt - e0) != 1 || doneCnt != d0 || toCnt != t0) begin
      bad++;
      $display("[TB] FAIL nack_pulses: err=%0d done=%0d to=%0d want 1 0 0",
               errCnt - e0, doneCnt - d0, toCnt - t0);
    end
    total++;
    if (bus.BUSY !== 1'b0 || bus.PS2CLK_OE !== 1'b0 || bus.PS2DATA_OE !== 1'b0) begin
      bad++;
      $display("[TB] FAIL nack_release: busy=%b clkoe=%b dataoe=%b want 0 0 0",
               bus.BUSY, bus.PS2CLK_OE, bus.PS2DATA_OE);
    end
  endtask

  task automatic test_timeout();
    int inhCnt, rtsCnt, sendCyc, toCyc;
    bit ok, seen;
    logic [10:0] bits;
    int d0, e0, t0;
    d0 = doneCnt; e0 = errCnt; t0 = toCnt;
    startTx(8'hA5);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    deviceBits(4, 1'b1, bits);
    seen = 1'b0;
    toCyc = 0;
    for (int i = 0; i < 600; i++) begin
      if (bus.TIMEOUT === 1'b1) begin
        seen = 1'b1;
        toCyc = cyc;
        break;
      end
      @(negedge CLK);
    end
    total++;
    if (!seen || (toCyc - sendCyc) != 500) begin
      bad++;
      $display("[TB] FAIL timeout_latency: seen=%0d delta=%0d want seen=1 delta=500", seen, toCyc - sendCyc);
    end
    @(negedge CLK);
    total++;
    if (bus.PS2CLK_OE !== 1'b0 || bus.PS2DATA_OE !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_release: clkoe=%b dataoe=%b busy=%b want 0 0 0",
               bus.PS2CLK_OE, bus.PS2DATA_OE, bus.BUSY);
    end
    total++;
    if ((toCnt - t0) != 1 || doneCnt != d0 || errCnt != e0) begin
      bad++;
      $display("[TB] FAIL timeout_pulses: to=%0d done=%0d err=%0d want 1 0 0",
               toCnt - t0, doneCnt - d0, errCnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    int inhCnt, rtsCnt, sendCyc;
    bit ok, doneOk;
    logic busyAtDone;
    logic [10:0] bits;
    int d0;
    startTx(8'hC3);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    deviceBits(6, 1'b1, bits);
    total++;
    if (bus.PS2DATA_OE !== 1'b1 || bus.BUSY !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_bit5_drive: dataoe=%b busy=%b want 1 1", bus.PS2DATA_OE, bus.BUSY);
    end
    ARST_L = 1'b0;
    #1;
    total++;
    if (bus.PS2CLK_OE !== 1'b0 || bus.PS2DATA_OE !== 1'b0 || bus.BUSY !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_release: clkoe=%b dataoe=%b busy=%b want 0 0 0",
               bus.PS2CLK_OE, bus.PS2DATA_OE, bus.BUSY);
    end
    repeat (2) @(negedge CLK);
    ARST_L = 1'b1;
    repeat (2) @(negedge CLK);
    d0 = doneCnt;
    startTx(8'hFF);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    deviceBits(11, 1'b1, bits);
    total++;
    if (bits !== 11'h7FE) begin
      bad++;
      $display("[TB] FAIL frame_ff: got %h want 7fe", bits);
    end
    waitDone(doneOk, busyAtDone);
    total++;
    if (!doneOk || (doneCnt - d0) != 1) begin
      bad++;
      $display("[TB] FAIL done_ff: seen=%0d count=%0d want 1 1", doneOk, doneCnt - d0);
    end
  endtask

  task automatic test_ignore();
    int inhCnt, rtsCnt, sendCyc, activeCyc;
    bit ok, doneOk;
    logic busyAtDone;
    logic [10:0] bits;
    int d0, e0, t0;
    d0 = doneCnt; e0 = errCnt; t0 = toCnt;
    startTx(8'h3C);
    repeat (3) @(negedge CLK);
    startTx(8'h81);
    observeInhibit(inhCnt, rtsCnt, sendCyc, ok);
    bus.TX_DATA  = 8'h81;
    bus.TX_START = 1'b1;
    @(negedge CLK);
    bus.TX_START = 1'b0;
    deviceBits(11, 1'b1, bits);
    total++;
    if (bits !== 11'h678) begin
      bad++;
      $display("[TB] FAIL ignore_frame: got %h want 678", bits);
    end
    waitDone(doneOk, busyAtDone);
    // Keyboard-style traffic while idle must not start anything.
    activeCyc = 0;
    for (int k = 0; k < 6; k++) begin
      devDataLow = k[0];
      devClkLow = 1'b1;
      for (int j = 0; j < 8; j++) begin
        @(negedge CLK);
        if (bus.BUSY !== 1'b0 || bus.PS2CLK_OE !== 1'b0 || bus.PS2DATA_OE !== 1'b0) activeCyc++;
      end
      devClkLow = 1'b0;
      for (int j = 0; j < 8; j++) begin
        @(negedge CLK);
        if (bus.BUSY !== 1'b0 || bus.PS2CLK_OE !== 1'b0 || bus.PS2DATA_OE !== 1'b0) activeCyc++;
      end
    end
    devDataLow = 1'b0;
    total++;
    if (activeCyc != 0) begin
      bad++;
      $display("[TB] FAIL idle_activity: got %0d active cycles want 0", activeCyc);
    end
    total++;
    if ((doneCnt - d0) != 1 || errCnt != e0 || toCnt != t0) begin
      bad++;
      $display("[TB] FAIL ignore_pulses: done=%0d err=%0d to=%0d want 1 0 0",
               doneCnt - d0, errCnt - e0, toCnt - t0);
    end
  endtask

  initial begin
    bus.TX_DATA  = 8'h00;
    bus.TX_START = 1'b0;
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
